// File: rtl/core_ctrl_if.sv
//==============================================================================
// Module      : core_ctrl_if
// Description : Host-side bundle of the core instruction sequencer. Carries
//               the tile request (start, base addresses, activation count,
//               accumulate enable), the output-FIFO status, and the
//               registered instruction word / status returned by the
//               sequencer.
//               master : host / testbench side
//               slave  : core_ctrl side
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface core_ctrl_if #(
    parameter int AW = 11
);
    logic          start;        // one-cycle tile request
    logic [AW-1:0] w_base;       // xMem base of the weight words
    logic [AW-1:0] x_base;       // xMem base of the activation words
    logic [AW-1:0] p_base;       // psumMem base for the results
    logic [AW-1:0] n_act;        // activation vector count, 1..2047
    logic          acc_en;       // run the accumulate phase after drain
    logic          ofifo_valid;  // core output FIFO holds a full row
    logic [33:0]   inst;         // core instruction word
    logic          busy;         // sequencer not idle
    logic          done;         // end-of-tile pulse

    modport master (
        output start, w_base, x_base, p_base, n_act, acc_en, ofifo_valid,
        input  inst, busy, done
    );

    modport slave (
        input  start, w_base, x_base, p_base, n_act, acc_en, ofifo_valid,
        output inst, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/core_ctrl.sv
//==============================================================================
// Module      : core_ctrl
// Description : Instruction sequencer for the 2D accelerator core. Each
//               accepted start runs one tile: weight fetch, kernel load,
//               gap, activation fetch, execute, wait for the output FIFO,
//               psum drain and an optional accumulate pass, then a one-cycle
//               done pulse.
// Ports       : clk   - sole clock, rising edge
//               reset - synchronous, active-high
//               bus   - core_ctrl_if.slave (request in, inst/busy/done out)
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module core_ctrl #(
    parameter int ROW = 8,
    parameter int COL = 8,
    parameter int AW  = 11
) (
    input  wire logic   clk,
    input  wire logic   reset,
    core_ctrl_if.slave  bus
);

    // Counter is one bit wider than an address so n_act (max 2047) plus the
    // extra latency cycle still fits.
    localparam int KW = AW + 1;

    // Both SRAMs deselected (CEN=1, WEN=1), everything else zero.
    localparam logic [33:0]   C_IDLE_WORD = 34'h1_800C_0000;
    localparam logic [KW-1:0] C_WF_LAST   = KW'(COL);
    localparam logic [KW-1:0] C_KL_LAST   = KW'(ROW + COL - 1);
    localparam logic [KW-1:0] C_KG_LAST   = KW'(ROW - 1);
    localparam logic [KW-1:0] C_COL       = KW'(COL);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_W_FETCH = 4'd1,
        S_K_LOAD  = 4'd2,
        S_K_GAP   = 4'd3,
        S_A_FETCH = 4'd4,
        S_A_EXEC  = 4'd5,
        S_D_WAIT  = 4'd6,
        S_DRAIN   = 4'd7,
        S_ACC     = 4'd8,
        S_DONE    = 4'd9
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [KW-1:0] r_k;
    logic [KW-1:0] w_k_nxt;

    logic [AW-1:0] r_w_base;
    logic [AW-1:0] r_x_base;
    logic [AW-1:0] r_p_base;
    logic [AW-1:0] r_n_act;
    logic          r_acc_en;

    logic [33:0]   r_inst;
    logic [33:0]   w_inst;
    logic          r_busy;
    logic          r_done;

    logic [KW-1:0] w_n;
    logic [KW-1:0] w_n_m1;
    logic [AW-1:0] w_kaddr;
    logic [AW-1:0] w_kaddr_m1;
    logic          w_accept;

    assign w_n        = {1'b0, r_n_act};
    assign w_n_m1     = w_n - KW'(1);
    assign w_kaddr    = r_k[AW-1:0];
    assign w_kaddr_m1 = w_kaddr - AW'(1);

    // Outputs lag the state by one flop. The cycle right after DONE shows
    // busy=1 while the state is already IDLE, so a start there must still
    // be ignored.
    assign w_accept = (r_state == S_IDLE) && !r_busy && bus.start &&
                      (bus.n_act != '0);

    //--------------------------------------------------------------------------
    // State register, parameter latches and registered outputs
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_k      <= '0;
            r_w_base <= '0;
            r_x_base <= '0;
            r_p_base <= '0;
            r_n_act  <= '0;
            r_acc_en <= 1'b0;
            r_inst   <= C_IDLE_WORD;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
            r_inst  <= w_inst;
            r_busy  <= (r_state != S_IDLE);
            r_done  <= (r_state == S_DONE);
            if (w_accept) begin
                r_w_base <= bus.w_base;
                r_x_base <= bus.x_base;
                r_p_base <= bus.p_base;
                r_n_act  <= bus.n_act;
                r_acc_en <= bus.acc_en;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Next state and in-state counter
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k + KW'(1);
        case (r_state)
            S_IDLE: begin
                w_k_nxt = '0;
                if (w_accept) w_state_nxt = S_W_FETCH;
            end
            S_W_FETCH: if (r_k == C_WF_LAST) begin
                w_state_nxt = S_K_LOAD;
                w_k_nxt     = '0;
            end
            S_K_LOAD: if (r_k == C_KL_LAST) begin
                w_state_nxt = S_K_GAP;
                w_k_nxt     = '0;
            end
            S_K_GAP: if (r_k == C_KG_LAST) begin
                w_state_nxt = S_A_FETCH;
                w_k_nxt     = '0;
            end
            S_A_FETCH: if (r_k == w_n) begin
                w_state_nxt = S_A_EXEC;
                w_k_nxt     = '0;
            end
            S_A_EXEC: if (r_k == w_n_m1) begin
                w_state_nxt = S_D_WAIT;
                w_k_nxt     = '0;
            end
            S_D_WAIT: begin
                w_k_nxt = '0;
                if (bus.ofifo_valid) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: if (r_k == w_n) begin
                w_state_nxt = r_acc_en ? S_ACC : S_DONE;
                w_k_nxt     = '0;
            end
            S_ACC: if (r_k == w_n) begin
                w_state_nxt = S_DONE;
                w_k_nxt     = '0;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_k_nxt     = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_k_nxt     = '0;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Instruction word for the current state/count. Reads lead the L0 write
    // (or accumulate) by one cycle to cover the SRAM read latency.
    //--------------------------------------------------------------------------
    always_comb begin
        w_inst = C_IDLE_WORD;
        case (r_state)
            S_W_FETCH: begin
                if (r_k < C_COL) begin
                    w_inst[7 +: AW] = r_w_base + w_kaddr;
                    w_inst[19]      = 1'b0;
                end
                if (r_k != '0) w_inst[3] = 1'b1;
            end
            S_K_LOAD: begin
                w_inst[0] = 1'b1;
                if (r_k < C_COL) w_inst[2] = 1'b1;
            end
            S_A_FETCH: begin
                if (r_k < w_n) begin
                    w_inst[7 +: AW] = r_x_base + w_kaddr;
                    w_inst[19]      = 1'b0;
                end
                if (r_k != '0) w_inst[3] = 1'b1;
            end
            S_A_EXEC: begin
                w_inst[1] = 1'b1;
                w_inst[2] = 1'b1;
            end
            S_DRAIN: begin
                if (r_k < w_n) w_inst[6] = 1'b1;
                if (r_k != '0) begin
                    w_inst[20 +: AW] = r_p_base + w_kaddr_m1;
                    w_inst[31]       = 1'b0;
                    w_inst[32]       = 1'b0;
                end
            end
            S_ACC: begin
                if (r_k < w_n) begin
                    w_inst[20 +: AW] = r_p_base + w_kaddr;
                    w_inst[32]       = 1'b0;
                end
                if (r_k != '0) w_inst[33] = 1'b1;
            end
            default: w_inst = C_IDLE_WORD;
        endcase
    end

    assign bus.inst = r_inst;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_core_ctrl.sv
//==============================================================================
// Module      : tb_core_ctrl
// Description : Self-checking bench for core_ctrl. A tile model expands each
//               request into its expected instruction-word sequence, queued
//               as a scoreboard; a monitor compares every busy cycle against
//               it. The output-FIFO wait is queued as a marker that absorbs
//               idle words, its length checked separately.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_core_ctrl;

    localparam int ROW = 8;
    localparam int COL = 8;
    localparam int AW  = 11;
    localparam logic [33:0] C_IDLE = 34'h1_800C_0000;

    typedef struct {
        logic [34:0] v;   // {done, inst}
        bit          dw;  // output-FIFO wait marker
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    core_ctrl_if #(.AW(AW)) bus ();

    core_ctrl #(.ROW(ROW), .COL(COL), .AW(AW)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    ent_t exp_q[$];
    int   dw_exp_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 1'b0;
    int   dw_cnt = 0;

    function automatic logic [33:0] mk(int flags, int xa, bit xcen,
                                       int pa, bit pwen, bit pcen, bit acc);
        logic [33:0] w;
        w        = '0;
        w[6:0]   = 7'(flags);
        w[17:7]  = 11'(xa);
        w[18]    = 1'b1;
        w[19]    = xcen;
        w[30:20] = 11'(pa);
        w[31]    = pwen;
        w[32]    = pcen;
        w[33]    = acc;
        return w;
    endfunction

    task automatic push(input logic [33:0] w, input bit d);
        ent_t e;
        e.v  = {d, w};
        e.dw = 1'b0;
        exp_q.push_back(e);
    endtask

    // Reference: phase-by-phase expected word stream of one tile.
    task automatic model_tile(input int wb, input int xb, input int pb,
                              input int n, input bit acc, input int dwait);
        ent_t m;
        for (int k = 0; k <= COL; k++)
            push(mk(k >= 1 ? 8 : 0, k < COL ? (wb + k) % 2048 : 0,
                    k < COL ? 1'b0 : 1'b1, 0, 1'b1, 1'b1, 1'b0), 1'b0);
        for (int k = 0; k < ROW + COL; k++)
            push(mk(1 | (k < COL ? 4 : 0), 0, 1'b1, 0, 1'b1, 1'b1, 1'b0), 1'b0);
        for (int k = 0; k < ROW; k++) push(C_IDLE, 1'b0);
        for (int k = 0; k <= n; k++)
            push(mk(k >= 1 ? 8 : 0, k < n ? (xb + k) % 2048 : 0,
                    k < n ? 1'b0 : 1'b1, 0, 1'b1, 1'b1, 1'b0), 1'b0);
        for (int k = 0; k < n; k++)
            push(mk(6, 0, 1'b1, 0, 1'b1, 1'b1, 1'b0), 1'b0);
        m.v  = '0;
        m.dw = 1'b1;
        exp_q.push_back(m);
        dw_exp_q.push_back(dwait);
        for (int k = 0; k <= n; k++)
            push(mk(k < n ? 64 : 0, 0, 1'b1, k >= 1 ? (pb + k - 1) % 2048 : 0,
                    k >= 1 ? 1'b0 : 1'b1, k >= 1 ? 1'b0 : 1'b1, 1'b0), 1'b0);
        if (acc)
            for (int k = 0; k <= n; k++)
                push(mk(0, 0, 1'b1, k < n ? (pb + k) % 2048 : 0, 1'b1,
                        k < n ? 1'b0 : 1'b1, k >= 1), 1'b0);
        push(C_IDLE, 1'b1);
    endtask

    // Monitor: compares every cycle against the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.busy) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_busy got=%h required=empty", {bus.done, bus.inst});
                end else begin
                    if (exp_q[0].dw && {bus.done, bus.inst} == {1'b0, C_IDLE}) begin
                        dw_cnt++;
                    end else begin
                        if (exp_q[0].dw) begin
                            total++;
                            if (dw_cnt != dw_exp_q[0]) begin
                                bad++;
                                $display("FAIL dwait_len got=%0d required=%0d", dw_cnt, dw_exp_q[0]);
                            end
                            void'(dw_exp_q.pop_front());
                            void'(exp_q.pop_front());
                            dw_cnt = 0;
                        end
                        if (exp_q.size() != 0) begin
                            total++;
                            if ({bus.done, bus.inst} !== exp_q[0].v) begin
                                bad++;
                                $display("FAIL seq got=%h required=%h", {bus.done, bus.inst}, exp_q[0].v);
                            end
                            void'(exp_q.pop_front());
                        end
                    end
                end
            end else begin
                total++;
                if ({bus.done, bus.inst} !== {1'b0, C_IDLE}) begin
                    bad++;
                    $display("FAIL idle_word got=%h required=%h", {bus.done, bus.inst}, {1'b0, C_IDLE});
                end
            end
        end
    end

    task automatic check(input string nm, input longint got, input longint req);
        total++;
        if (got != req) begin
            bad++;
            $display("FAIL %s got=%0d required=%0d", nm, got, req);
        end
    endtask

    // Runs one tile. stall: hold ofifo_valid low 20 cycles past the end of
    // execute (valid rises after the 21st edge past the last execute word,
    // giving 22 wait words). poke: pulse start and scramble inputs mid-run.
    task automatic run_tile(input int wb, input int xb, input int pb,
                            input int n, input bit acc, input bit stall,
                            input bit poke);
        int  cycles, dwait, sc, expc;
        bit  seen_exec, cnt_on;
        dwait = stall ? 22 : 1;
        model_tile(wb, xb, pb, n, acc, dwait);
        @(negedge clk);
        bus.w_base = 11'(wb); bus.x_base = 11'(xb); bus.p_base = 11'(pb);
        bus.n_act = 11'(n); bus.acc_en = acc;
        bus.ofifo_valid = !stall;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        if (poke) begin
            bus.w_base = 11'($urandom_range(2047, 0));
            bus.x_base = 11'($urandom_range(2047, 0));
            bus.p_base = 11'($urandom_range(2047, 0));
            bus.n_act  = 11'($urandom_range(2047, 1));
            bus.acc_en = !acc;
        end
        cycles = 0; seen_exec = 0; cnt_on = 0; sc = 0;
        while (1) begin
            @(posedge clk);
            cycles++;
            #1;
            bus.start = poke && (cycles == 30 || cycles == 150);
            if (stall) begin
                if (cnt_on) begin
                    sc++;
                    if (sc == 20) bus.ofifo_valid = 1'b1;
                end else if (seen_exec && !bus.inst[1]) begin
                    cnt_on = 1;
                end
                if (bus.inst[1]) seen_exec = 1;
            end
            if (bus.done || cycles > 20000) break;
        end
        bus.start = 1'b0;
        expc = (COL + 1) + (ROW + COL) + ROW + (n + 1) + n + dwait + (n + 1) +
               (acc ? n + 1 : 0) + 1;
        check("done_latency", cycles, expc);
        repeat (3) @(posedge clk);
        #1 check("queue_drained", exp_q.size(), 0);
        if (exp_q.size() != 0) begin
            exp_q.delete();
            dw_exp_q.delete();
        end
    endtask

    initial begin
        int sb;
        bus.start = 1'b0; bus.w_base = '0; bus.x_base = '0; bus.p_base = '0;
        bus.n_act = '0; bus.acc_en = 1'b0; bus.ofifo_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_inst", bus.inst, C_IDLE);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        reset = 1'b0;
        mon_en = 1'b1;

        run_tile(0, 64, 0, 36, 0, 0, 0);         // nominal
        run_tile(0, 64, 0, 36, 1, 0, 0);         // accumulate
        run_tile(0, 64, 0, 36, 0, 1, 0);         // drain stall
        run_tile(100, 2040, 2030, 16, 1, 0, 0);  // wrap
        run_tile(7, 300, 500, 20, 1, 0, 1);      // start while busy, inputs change

        // n_act = 0 is ignored
        @(negedge clk);
        bus.n_act = '0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        sb = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.busy || bus.done) sb++;
        end
        check("nact0_ignored", sb, 0);

        // reset and start together: reset wins
        @(negedge clk);
        reset = 1'b1; bus.n_act = 11'd5; bus.start = 1'b1;
        @(negedge clk);
        reset = 1'b0; bus.start = 1'b0;
        sb = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (bus.busy) sb++;
        end
        check("rst_start_drop", sb, 0);

        // reset during execute
        mon_en = 1'b0;
        @(negedge clk);
        bus.w_base = '0; bus.x_base = 11'd64; bus.p_base = '0;
        bus.n_act = 11'd36; bus.acc_en = 1'b1; bus.ofifo_valid = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        sb = 0;
        while (!bus.inst[1] && sb < 500) begin
            @(negedge clk);
            sb++;
        end
        check("exec_reached", bus.inst[1], 1);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_inst", bus.inst, C_IDLE);
        check("midrst_busy", bus.busy, 0);
        check("midrst_done", bus.done, 0);
        @(negedge clk);
        reset = 1'b0;
        mon_en = 1'b1;
        run_tile(0, 64, 0, 36, 0, 0, 0);

        // randomized tiles
        for (int t = 0; t < 6; t++)
            run_tile($urandom_range(2047, 0), $urandom_range(2047, 0),
                     $urandom_range(2047, 0), $urandom_range(40, 1),
                     1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                     1'($urandom_range(1, 0)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
